// File: rtl/apb_completer_pkg.sv
// Shared types and limits for the APB completer register bank.
package apb_completer_pkg;

  localparam int APB_AW          = 16;
  localparam int APB_DW          = 16;
  localparam int MAX_NUM_REGS    = 32;
  localparam int MAX_WAIT_STATES = 15;

  // Index wide enough for the largest bank; counter wide enough for the longest stall.
  localparam int IDX_W = $clog2(MAX_NUM_REGS);
  localparam int CNT_W = $clog2(MAX_WAIT_STATES + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/apb_completer_regs_if.sv
// APB3 bus bundle between an initiator and the register-bank completer.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) and
// continues with access cycles (PSEL=1, PENABLE=1). It completes in the access
// cycle where PREADY=1; PRDATA and PSLVERR are meaningful only in that cycle.
// Address, direction and write data must stay stable from setup to completion.
interface apb_completer_regs_if;
  import apb_completer_pkg::*;

  logic [APB_AW-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_completer_decode.sv
// Address decoder: maps a byte address onto a 16-bit register index and flags
// addresses that are below the base, odd, or beyond the last register.
module apb_completer_decode
  import apb_completer_pkg::*;
#(
  parameter int                NUM_REGS  = 8,
  parameter logic [APB_AW-1:0] BASE_ADDR = 16'h0000
) (
  input  logic [APB_AW-1:0] paddr,
  output logic [IDX_W-1:0]  index,
  output logic              err
);

  logic [APB_AW-1:0] offset;
  logic [APB_AW-1:0] word;

  // Offset from base, halved to a word index; the full-width word is range-checked.
  always_comb begin
    offset = paddr - BASE_ADDR;
    word   = {1'b0, offset[APB_AW-1:1]};
    index  = word[IDX_W-1:0];
    // BASE_ADDR is even, so offset[0] equals paddr[0].
    err    = (paddr < BASE_ADDR) | offset[0] | (word >= APB_AW'(NUM_REGS));
  end

endmodule

// File: rtl/apb_completer_regs.sv
// APB3 completer exposing a bank of 16-bit control/status registers with a
// fixed number of wait states, PSLVERR on bad addresses and per-register
// write strobes for the SPI core.
module apb_completer_regs
  import apb_completer_pkg::*;
#(
  parameter int                NUM_REGS    = 8,
  parameter logic [APB_AW-1:0] BASE_ADDR   = 16'h0000,
  parameter int                WAIT_STATES = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  apb_completer_regs_if.slave      apb,
  output logic [16*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse,
  output state_t                   dbg_state
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              hold_write;
  logic [APB_DW-1:0] hold_wdata;
  logic [IDX_W-1:0]  hold_idx;
  logic              hold_err;
  logic [APB_DW-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]  dec_idx;
  logic              dec_err;
  logic              done;
  logic [APB_DW-1:0] rd_word;

  apb_completer_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .paddr (apb.PADDR),
    .index (dec_idx),
    .err   (dec_err)
  );

  // FSM, wait counter, holding registers, register bank and write strobes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_write <= 1'b0;
      hold_wdata <= '0;
      hold_idx   <= '0;
      hold_err   <= 1'b0;
      wr_pulse   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      case (state)
        IDLE: begin
          // Only a genuine setup phase starts a transfer; a bare access phase is ignored.
          if (apb.PSEL && !apb.PENABLE) begin
            state      <= ACCESS;
            cnt        <= CNT_W'(WAIT_STATES);
            hold_write <= apb.PWRITE;
            hold_wdata <= apb.PWDATA;
            hold_idx   <= dec_idx;
            hold_err   <= dec_err;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            // Initiator gave up while we were stalling: drop the transfer.
            if (!apb.PSEL) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else begin
            state <= IDLE;
            if (hold_write && !hold_err) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (hold_idx == IDX_W'(i)) begin
                  regs[i]     <= hold_wdata;
                  wr_pulse[i] <= 1'b1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  // Response path built only from registered state; read data tracks live register contents.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hold_idx == IDX_W'(i)) rd_word = regs[i];
    end
    done        = (state == ACCESS) && (cnt == '0);
    apb.PREADY  = done;
    apb.PSLVERR = done && hold_err;
    apb.PRDATA  = (done && !hold_write && !hold_err) ? rd_word : '0;
  end

  // Flatten the register bank for the SPI core.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[16*i +: 16] = regs[i];
  end

  assign dbg_state = state;

endmodule

// File: doc/apb_completer_regs.md
# apb_completer_regs

Synthesizable APB3 completer that gives the SPI design a memory-mapped control/status register bank. It answers transfers from the APB initiator on the same bus the agent's monitor BFM observes, inserting a fixed number of wait states. It flags bad addresses with PSLVERR and exports register contents plus per-register write strobes to the SPI core.

## Interface
- NUM_REGS, 8: number of 16-bit registers, 1..32.
- BASE_ADDR, 16'h0000: byte address of register 0; must be even.
- WAIT_STATES, 0: PREADY-low cycles inserted in each access phase, 0..15.

- PCLK  in  1  bus clock; all state updates on rising edge.
- PRESETn  in  1  reset, asynchronous assert, active-low.
- PADDR  in  16  byte address.
- PSEL  in  1  this completer's select line.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  16  write data.
- PRDATA  out  16  read data; valid only while PREADY=1 on a non-error read, else 0.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1, else 0.
- reg_q  out  16*NUM_REGS  flattened register contents, reg i at [16i+15:16i].
- wr_pulse  out  NUM_REGS  one-cycle strobe, bit i set the cycle after reg i is written.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase). On that edge:
  - capture PWRITE, PWDATA and the decoded index/error into holding registers;
  - load the wait counter with WAIT_STATES.
- IDLE with PSEL=1 and PENABLE=1 and no prior setup: ignore, stay in IDLE, PREADY=0.
- In ACCESS:
  - While the counter is nonzero, PREADY=0 and the counter decrements.
  - When the counter is 0, PREADY=1 and the transfer completes that cycle. FSM returns to IDLE at the next edge.
- Decode:
  - offset = PADDR − BASE_ADDR (16-bit unsigned); index = offset>>1.
  - Error if PADDR < BASE_ADDR, PADDR[0]=1, or index ≥ NUM_REGS.
- Write completion, non-error: reg[index] <= captured PWDATA and wr_pulse[index] <= 1 at the completing edge. wr_pulse clears at the following edge.
- Write completion, error: no register changes, PSLVERR=1.
- Read completion: PRDATA = reg[index]. On error, PRDATA = 0 and PSLVERR = 1.
- Abort: if PSEL drops in ACCESS before completion, return to IDLE with no write and no strobe.
- Simultaneous events: the completion cycle always returns to IDLE. A setup phase presented in the next cycle is accepted normally, giving back-to-back transfers with no idle gap.
- Reset, including mid-transfer: state IDLE, counter 0, all registers 0, PREADY=0, PSLVERR=0, PRDATA=0, wr_pulse=0. Any in-flight write is discarded.

## Timing
- WAIT_STATES=0: setup cycle n, access cycle n+1 with PREADY=1. reg_q and wr_pulse update at the end of cycle n+1 and are visible in cycle n+2.
- General: PREADY rises in cycle n+1+WAIT_STATES. A transfer occupies 2+WAIT_STATES cycles.
- PREADY, PRDATA and PSLVERR depend only on registered state and the holding registers, with no combinational path from bus inputs.
  - Exception: PRDATA reflects the current register contents. A register written in the preceding transfer is therefore read back correctly in the next one.
- Throughput: one transfer per 2+WAIT_STATES cycles.

## Structure
- apb_completer_pkg holds:
  - state typedef enum {IDLE, ACCESS};
  - APB_AW=16 and APB_DW=16 constants;
  - the max NUM_REGS and max WAIT_STATES constants.
- One combinational sub-module, apb_completer_decode. It takes PADDR, BASE_ADDR and NUM_REGS and produces index and err. It is instantiated once and reused by any future completer.
- The top holds the FSM, wait counter, holding registers, register array and strobe logic.

## Test plan
- Reset, then write 0xA5A5 to 0x0004 and read 0x0004 with WAIT_STATES=0 -> PREADY high in cycle 2 of each transfer, PRDATA=0xA5A5, reg_q[47:32]=0xA5A5, wr_pulse=8'h04 for exactly one cycle, PSLVERR=0.
- WAIT_STATES=3, read 0x0000 after reset -> PREADY low for 3 access cycles then high for 1, PRDATA=0x0000.
- Write to 0x0010 (index 8, NUM_REGS=8) and to odd address 0x0003 -> PSLVERR=1 with PREADY, reg_q unchanged, wr_pulse stays 0. A following read of 0x0010 -> PRDATA=0, PSLVERR=1.
- Back-to-back: write 0x1234 to 0x0002 immediately followed by a read of 0x0002 with no idle cycle -> read returns 0x1234. Two transfers complete in 4 cycles.
- WAIT_STATES=2: write 0xFFFF to 0x0006, drop PSEL during the first wait cycle -> no completion, reg 3 stays 0. The next setup is accepted normally.
- Assert PRESETn=0 during a write's access phase -> all outputs 0 immediately, registers 0. After release, a read of the targeted register returns 0.
